// File: rtl/monster_pkg.sv
// rtl/monster_pkg.sv - shared state encoding, HP/damage constants and min helper for the monster HP controller
package monster_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_DEAD  = 3'd5
    } state_t;

    localparam int MAX_HP_DEFAULT = 100;

    // Base damage of the attack gauge, shared with the gauge block.
    localparam logic [7:0] ATK_BASE_DAMAGE = 8'd20;

    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        m = (m < c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/monster_hp_ctrl_hp_drain.sv
// rtl/monster_hp_ctrl_hp_drain.sv - hp and pending-damage registers with saturating per-tick drain
module hp_drain
    import monster_pkg::*;
#(
    parameter int MAX_HP     = MAX_HP_DEFAULT,
    parameter int DRAIN_STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_damage,
    input  logic       i_step_en,
    input  logic       i_clr_pending,
    input  logic       i_regen,
    output logic [7:0] o_hp,
    output logic [7:0] o_pending
);

    localparam logic [7:0] HP_MAX8 = 8'(MAX_HP);
    localparam logic [7:0] STEP8   = 8'(DRAIN_STEP);

    logic [7:0] r_hp;
    logic [7:0] r_pending;
    logic [7:0] w_step;

    // Step never exceeds what is pending or what hp is left, so neither register can wrap.
    assign w_step = min3(r_pending, STEP8, r_hp);

    // Latch damage on pass, drain on tick, clear pending at turn end, regen by one when allowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hp      <= HP_MAX8;
            r_pending <= 8'd0;
        end else begin
            if (i_load) begin
                r_pending <= i_damage;
            end else if (i_clr_pending) begin
                r_pending <= 8'd0;
            end else if (i_step_en) begin
                r_pending <= r_pending - w_step;
                r_hp      <= r_hp - w_step;
            end
            if (i_regen && (r_hp < HP_MAX8)) begin
                r_hp <= r_hp + 8'd1;
            end
        end
    end

    assign o_hp      = r_hp;
    assign o_pending = r_pending;

endmodule

// File: rtl/monster_hp_ctrl.sv
// rtl/monster_hp_ctrl.sv - player-attack consumer FSM; optional idle regeneration under MONSTER_REGEN_EN
module monster_hp_ctrl
    import monster_pkg::*;
#(
    parameter int MAX_HP       = MAX_HP_DEFAULT,
    parameter int DRAIN_STEP   = 1
`ifdef MONSTER_REGEN_EN
    ,
    parameter int REGEN_PERIOD = 60
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       begin_turn,
    input  logic       pass,
    input  logic [7:0] damage,
    input  logic       tick,
    output logic       atk_clr,
    output logic       atk_start,
    output logic [7:0] hp,
    output logic       miss,
    output logic       done,
    output logic       dead
);

    state_t     r_state;
    logic       r_atk_clr;
    logic       r_atk_start;
    logic       r_miss;
    logic       r_done;
    logic       r_dead;
    logic [7:0] w_hp;
    logic [7:0] w_pending;
    logic       w_load;
    logic       w_step_en;
    logic       w_clr_pending;
    logic       w_regen_inc;

    assign w_load        = (r_state == ST_WAIT) && pass;
    assign w_step_en     = (r_state == ST_DRAIN) && tick;
    assign w_clr_pending = (r_state == ST_DONE);

`ifdef MONSTER_REGEN_EN
    localparam int CW = $clog2(REGEN_PERIOD + 1);
    logic [CW-1:0] r_regen_cnt;

    // Count idle ticks; any departure from IDLE restarts the regeneration period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regen_cnt <= '0;
        end else if ((r_state != ST_IDLE) || begin_turn) begin
            r_regen_cnt <= '0;
        end else if (tick) begin
            r_regen_cnt <= (r_regen_cnt == CW'(REGEN_PERIOD - 1)) ? '0 : r_regen_cnt + 1'b1;
        end
    end

    assign w_regen_inc = (r_state == ST_IDLE) && !begin_turn && tick &&
                         (r_regen_cnt == CW'(REGEN_PERIOD - 1));
`else
    assign w_regen_inc = 1'b0;
`endif

    hp_drain #(
        .MAX_HP     (MAX_HP),
        .DRAIN_STEP (DRAIN_STEP)
    ) u_hp_drain (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_load),
        .i_damage      (damage),
        .i_step_en     (w_step_en),
        .i_clr_pending (w_clr_pending),
        .i_regen       (w_regen_inc),
        .o_hp          (w_hp),
        .o_pending     (w_pending)
    );

    // Turn sequencing FSM; every output is registered and set alongside the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_atk_clr   <= 1'b0;
            r_atk_start <= 1'b0;
            r_miss      <= 1'b0;
            r_done      <= 1'b0;
            r_dead      <= 1'b0;
        end else begin
            r_atk_clr <= 1'b0;
            r_miss    <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (begin_turn && !r_dead) begin
                        r_state   <= ST_ARM;
                        r_atk_clr <= 1'b1;
                    end
                end
                ST_ARM: begin
                    r_state     <= ST_WAIT;
                    r_atk_start <= 1'b1;
                end
                ST_WAIT: begin
                    if (pass) begin
                        r_atk_start <= 1'b0;
                        if (damage == 8'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_miss  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((w_pending == 8'd0) || (w_hp == 8'd0)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_hp == 8'd0) begin
                        r_state <= ST_DEAD;
                        r_dead  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    r_atk_start <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign atk_clr   = r_atk_clr;
    assign atk_start = r_atk_start;
    assign hp        = w_hp;
    assign miss      = r_miss;
    assign done      = r_done;
    assign dead      = r_dead;

endmodule

// File: tb/tb_monster_hp_ctrl.sv
// tb/tb_monster_hp_ctrl.sv - directed self-checking bench for monster_hp_ctrl
module tb_monster_hp_ctrl;
    import monster_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       begin_turn = 1'b0;
    logic       pass = 1'b0;
    logic [7:0] damage = 8'd0;
    logic       tick = 1'b0;

    logic       atk_clr, atk_start, miss, done, dead;
    logic [7:0] hp;
    logic       atk_clr4, atk_start4, miss4, done4, dead4;
    logic [7:0] hp4;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int miss_cnt = 0;
    int clr_cnt = 0;
    int miss_at_done = 0;

    always #5 clk = ~clk;

    monster_hp_ctrl #(.MAX_HP(100), .DRAIN_STEP(1)) dut (
        .clk(clk), .reset(reset), .begin_turn(begin_turn), .pass(pass), .damage(damage),
        .tick(tick), .atk_clr(atk_clr), .atk_start(atk_start), .hp(hp), .miss(miss),
        .done(done), .dead(dead)
    );

    monster_hp_ctrl #(.MAX_HP(100), .DRAIN_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .begin_turn(begin_turn), .pass(pass), .damage(damage),
        .tick(tick), .atk_clr(atk_clr4), .atk_start(atk_start4), .hp(hp4), .miss(miss4),
        .done(done4), .dead(dead4)
    );

`ifdef MONSTER_REGEN_EN
    logic       atk_clr_r, atk_start_r, miss_r, done_r, dead_r;
    logic [7:0] hp_r;

    monster_hp_ctrl #(.MAX_HP(100), .DRAIN_STEP(10), .REGEN_PERIOD(3)) dutr (
        .clk(clk), .reset(reset), .begin_turn(begin_turn), .pass(pass), .damage(damage),
        .tick(tick), .atk_clr(atk_clr_r), .atk_start(atk_start_r), .hp(hp_r), .miss(miss_r),
        .done(done_r), .dead(dead_r)
    );
`endif

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge, tallying pulses of the main DUT.
    task automatic step();
        @(posedge clk);
        #1;
        if (done) begin
            done_cnt++;
            miss_at_done = int'(miss);
        end
        if (miss) miss_cnt++;
        if (atk_clr) clr_cnt++;
    endtask

    task automatic run_turn(input logic [7:0] dmg, input int nticks);
        done_cnt = 0;
        miss_cnt = 0;
        clr_cnt = 0;
        miss_at_done = 0;
        begin_turn = 1'b1;
        step();
        begin_turn = 1'b0;
        check("arm_clr", int'(atk_clr), 1);
        step();
        check("start_lat", int'(atk_start), 1);
        pass = 1'b1;
        damage = dmg;
        step();
        damage = 8'hFF;
        for (int i = 0; i < nticks; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        for (int i = 0; i < 10; i++) begin
            if (done_cnt == 0) step();
        end
        check("done_seen", done_cnt, 1);
        step();
        step();
        pass = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b1;
        step();

        // Reset state.
        check("rst_hp", int'(hp), 100);
        check("rst_start", int'(atk_start), 0);
        check("rst_done", int'(done), 0);
        check("rst_dead", int'(dead), 0);

        // DRAIN_STEP=4 and regen instance share this stimulus.
        begin_turn = 1'b1;
        step();
        begin_turn = 1'b0;
        check("s4_clr", int'(atk_clr4), 1);
`ifdef MONSTER_REGEN_EN
        check("rg_clr", int'(atk_clr_r), 1);
`endif
        step();
        check("s4_start", int'(atk_start4), 1);
`ifdef MONSTER_REGEN_EN
        check("rg_start", int'(atk_start_r), 1);
`endif
        pass = 1'b1;
        damage = 8'd10;
        tick = 1'b1;
        step();
        damage = 8'hFF;
        check("s4_pass_tick_ignored", int'(hp4), 100);
        step();
        check("s4_hp96", int'(hp4), 96);
`ifdef MONSTER_REGEN_EN
        check("rg_hp90", int'(hp_r), 90);
`endif
        step();
        check("s4_hp92", int'(hp4), 92);
`ifdef MONSTER_REGEN_EN
        check("rg_done", int'(done_r), 1);
        check("rg_miss", int'(miss_r), 0);
`endif
        step();
        check("s4_hp90", int'(hp4), 90);
        tick = 1'b0;
        step();
        check("s4_done", int'(done4), 1);
        check("s4_miss", int'(miss4), 0);
        check("s4_dead", int'(dead4), 0);
        check("s4_hp_final", int'(hp4), 90);
`ifdef MONSTER_REGEN_EN
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        check("rg_hp91", int'(hp_r), 91);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        check("rg_hp92", int'(hp_r), 92);
        check("rg_dead", int'(dead_r), 0);
`endif
        pass = 1'b0;

        // Fresh reset for the main instance.
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
`ifdef MONSTER_REGEN_EN
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        check("rg_cap100", int'(hp_r), 100);
`endif

        // Hit.
        run_turn(ATK_BASE_DAMAGE, 20);
        check("hit_hp80", int'(hp), 80);
        check("hit_clr_cnt", clr_cnt, 1);
        check("hit_done_cnt", done_cnt, 1);
        check("hit_miss_cnt", miss_cnt, 0);
        check("hit_start_low", int'(atk_start), 0);

        // Asynchronous reset mid-WAIT.
        begin_turn = 1'b1;
        step();
        begin_turn = 1'b0;
        step();
        check("wait_start", int'(atk_start), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_hp", int'(hp), 100);
        check("arst_start", int'(atk_start), 0);
        check("arst_done", int'(done), 0);
        check("arst_dead", int'(dead), 0);
        #2;
        reset = 1'b1;
        step();

        // Miss.
        run_turn(8'd0, 0);
        check("miss_done_cnt", done_cnt, 1);
        check("miss_cnt", miss_cnt, 1);
        check("miss_with_done", miss_at_done, 1);
        check("miss_hp", int'(hp), 100);

        // Overkill: bring hp to 15, then deal 20.
        run_turn(8'd85, 85);
        check("ok_hp15", int'(hp), 15);
        check("ok_alive", int'(dead), 0);
        run_turn(8'd20, 15);
        check("ok_hp0", int'(hp), 0);
        check("ok_done_cnt", done_cnt, 1);
        check("ok_dead", int'(dead), 1);
        check("ok_miss_cnt", miss_cnt, 0);

        // begin_turn ignored once dead.
        clr_cnt = 0;
        begin_turn = 1'b1;
        step();
        begin_turn = 1'b0;
        step();
        step();
        check("dead_no_clr", clr_cnt, 0);
        check("dead_no_start", int'(atk_start), 0);
        check("dead_sticky", int'(dead), 1);
        check("dead_hp", int'(hp), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
